// File: rtl/mcu_bus_pkg.sv
// Shared definitions for the MCU bus master: FSM states, default phase
// timings and the register addresses and readback values used with the
// register-file responder.
package mcu_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } bus_state_t;

    localparam int DEF_ALE_CYCLES     = 3;
    localparam int DEF_SETUP_CYCLES   = 2;
    localparam int DEF_STROBE_CYCLES  = 4;
    localparam int DEF_HOLD_CYCLES    = 2;
    localparam int DEF_RECOVER_CYCLES = 1;
    localparam int DEF_WAIT_TIMEOUT   = 64;

    // Value the responder returns for addresses it does not decode
    localparam logic [7:0] UNMAPPED_RDATA = 8'hC9;

    localparam logic [7:0] REG_TEST   = 8'hFF;
    localparam logic [7:0] REG_FAULT  = 8'h08;
    localparam logic [7:0] REG_KICKER = 8'h21;

    // Phase counters run N-1 down to 0, so a phase lasts exactly N clocks
    function automatic logic [7:0] phase_load(input int cycles);
        return 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/mcu_bus_phase_timer.sv
// 8-bit loadable down-counter. A load takes priority; otherwise the count
// decrements and parks at zero. zero flags the final cycle of a phase.
module mcu_bus_phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic       zero
);

    logic [7:0] count;

    // Load on phase entry, then count down to zero and hold there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_value;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/mcu_bus_master.sv
// Initiator for the 8-bit multiplexed address/data MCU bus. Converts a
// command/response stream into ADDR/SETUP/STROBE/HOLD/RECOVER bus cycles.
// Optional build macro MCU_BUS_WAIT_EN enables responder wait extension
// with a timeout; without it wait_n is ignored and rsp_err stays 0.
import mcu_bus_pkg::*;

module mcu_bus_master #(
    parameter int ALE_CYCLES     = DEF_ALE_CYCLES,
    parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES  = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES,
    parameter int WAIT_TIMEOUT   = DEF_WAIT_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       ale_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    input  logic       wait_n
);

    bus_state_t state;
    logic       lat_write;
    logic [7:0] lat_addr;
    logic [7:0] lat_wdata;

    logic       accept;
    logic       timer_load;
    logic [7:0] timer_value;
    logic       timer_zero;
    logic       wait_ok;
    logic       extending;
    logic       extend_start;
    logic       strobe_exit;
    logic       strobe_err;

    mcu_bus_phase_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

`ifdef MCU_BUS_WAIT_EN
    logic [1:0] wait_sync;

    // Two-flop synchronizer for the responder's asynchronous wait line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_sync <= 2'b11;
        end else begin
            wait_sync <= {wait_sync[0], wait_n};
        end
    end

    assign wait_ok = wait_sync[1];

    // Marks that STROBE has run past its nominal length and the timer now counts the timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            extending <= 1'b0;
        end else if (extend_start) begin
            extending <= 1'b1;
        end else if (state != ST_STROBE) begin
            extending <= 1'b0;
        end
    end
`else
    logic unused_wait;
    assign wait_ok     = 1'b1;
    assign extending   = 1'b0;
    assign unused_wait = wait_n | (WAIT_TIMEOUT == 0);
`endif

    assign accept       = cmd_valid && cmd_ready;
    assign extend_start = (state == ST_STROBE) && !extending && timer_zero && !wait_ok;
    assign strobe_exit  = (state == ST_STROBE) &&
                          (extending ? (wait_ok || timer_zero) : (timer_zero && wait_ok));
    // Leaving an extension while wait is still asserted means the timeout expired
    assign strobe_err   = extending && !wait_ok;

    // Reload the phase timer on every state entry, and when STROBE starts its extension
    always_comb begin
        timer_load  = 1'b0;
        timer_value = 8'd0;
        case (state)
            ST_IDLE: if (accept) begin
                timer_load  = 1'b1;
                timer_value = phase_load(ALE_CYCLES);
            end
            ST_ADDR: if (timer_zero) begin
                timer_load  = 1'b1;
                timer_value = phase_load(SETUP_CYCLES);
            end
            ST_SETUP: if (timer_zero) begin
                timer_load  = 1'b1;
                timer_value = phase_load(STROBE_CYCLES);
            end
            ST_STROBE: if (strobe_exit) begin
                timer_load  = 1'b1;
                timer_value = phase_load(HOLD_CYCLES);
            end else if (extend_start) begin
                timer_load  = 1'b1;
                timer_value = phase_load(WAIT_TIMEOUT);
            end
            ST_HOLD: if (timer_zero) begin
                timer_load  = 1'b1;
                timer_value = phase_load(RECOVER_CYCLES);
            end
            default: begin
                timer_load  = 1'b0;
                timer_value = 8'd0;
            end
        endcase
    end

    // Bus cycle sequencer; every output is registered and set on entry to its state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
            ale_n     <= 1'b1;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            ad_out    <= 8'h00;
            ad_oe     <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= 8'h00;
            lat_wdata <= 8'h00;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        lat_write <= cmd_write;
                        lat_addr  <= cmd_addr;
                        lat_wdata <= cmd_wdata;
                        ale_n     <= 1'b0;
                        ad_oe     <= 1'b1;
                        ad_out    <= cmd_addr;
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: if (timer_zero) begin
                    ale_n <= 1'b1;
                    ad_oe <= lat_write;
                    if (lat_write) begin
                        ad_out <= lat_wdata;
                    end
                    state <= ST_SETUP;
                end
                ST_SETUP: if (timer_zero) begin
                    wr_n  <= !lat_write;
                    rd_n  <= lat_write;
                    ad_oe <= lat_write;
                    state <= ST_STROBE;
                end
                ST_STROBE: if (strobe_exit) begin
                    wr_n    <= 1'b1;
                    rd_n    <= 1'b1;
                    rsp_err <= strobe_err;
                    if (strobe_err) begin
                        rsp_rdata <= 8'h00;
                    end else if (!lat_write) begin
                        rsp_rdata <= ad_in;
                    end
                    state <= ST_HOLD;
                end
                ST_HOLD: if (timer_zero) begin
                    ad_oe     <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= ST_RECOVER;
                end
                ST_RECOVER: if (timer_zero) begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_bus_master.sv
// Testbench for mcu_bus_master: a register-file responder on the bus, a
// driver that pushes expected responses from a high-level register model,
// and a monitor that checks responses, phase lengths and bus rules.
`timescale 1ns/1ps

module tb_mcu_bus_master;
    import mcu_bus_pkg::*;

    localparam int A = DEF_ALE_CYCLES;
    localparam int S = DEF_SETUP_CYCLES;
    localparam int P = DEF_STROBE_CYCLES;
    localparam int H = DEF_HOLD_CYCLES;
    localparam int R = DEF_RECOVER_CYCLES;
    localparam int T = DEF_WAIT_TIMEOUT;
    localparam logic [7:0] REG_STATUS = 8'h13;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       ale_n, rd_n, wr_n, ad_oe;
    logic [7:0] ad_out;
    logic [7:0] ad_in;
    logic       wait_n = 1'b1;

    always #5 clk = ~clk;

    mcu_bus_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ale_n(ale_n), .rd_n(rd_n), .wr_n(wr_n),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .wait_n(wait_n)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // ---------------- register-file responder on the bus ----------------
    logic [7:0] resp_addr = 8'h00;
    logic [7:0] resp_test = 8'h00, resp_fault = 8'h00, resp_kicker = 8'h00;
    logic [7:0] resp_wdata = 8'h00;
    logic       resp_wr_seen = 1'b0;

    function automatic logic [7:0] resp_read(input logic [7:0] a);
        case (a)
            REG_TEST:   return resp_test;
            REG_FAULT:  return resp_fault;
            REG_KICKER: return resp_kicker;
            REG_STATUS: return 8'h0F;   // switches 4'b0000, button released
            default:    return UNMAPPED_RDATA;
        endcase
    endfunction

    assign ad_in = (!rd_n) ? resp_read(resp_addr) : 8'hEE;

    // Latch address on ALE; commit a write only if data is still driven once WR rises
    always @(posedge clk) begin
        if (!ale_n && ad_oe) resp_addr <= ad_out;
        if (!wr_n) begin
            resp_wr_seen <= 1'b1;
            resp_wdata   <= ad_out;
        end else begin
            if (resp_wr_seen && ad_oe) begin
                case (resp_addr)
                    REG_TEST:   resp_test   <= resp_wdata;
                    REG_FAULT:  resp_fault  <= resp_wdata;
                    REG_KICKER: resp_kicker <= resp_wdata;
                    default: ;
                endcase
            end
            resp_wr_seen <= 1'b0;
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       err;
        int         stb_len;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mdl_val [0:255];
    bit         mdl_rw  [0:255];
    logic [7:0] last_rdata = 8'h00;

    function automatic logic [7:0] mdl_read(input logic [7:0] a);
        if (a == REG_STATUS) return 8'h0F;
        if (mdl_rw[a])       return mdl_val[a];
        return UNMAPPED_RDATA;
    endfunction

    // ---------------- monitor ----------------
    int  ncyc = 0;
    int  acc_cyc = 0;
    bit  acc_flag = 0;
    bit  accepted = 0;
    int  ale_cnt = 0, stb_cnt = 0;
    bit  ready_prev = 0, ale_prev = 1;
    bit  in_read = 0;
    int  exp_ready = 0;
    bit  held_mode = 0;
    int  held_cnt = 0;
    int  prev_acc = 0;

    // Accepts are sampled at the active edge, before the DUT updates cmd_ready
    always @(posedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) acc_flag = 1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            accepted = 0; ready_prev = 0; ale_prev = 1; in_read = 0;
            ale_cnt = 0; stb_cnt = 0; acc_flag = 0;
        end else begin
            ncyc++;
            chk("protocol", int'((!rd_n && !wr_n) || (!ale_n && (!rd_n || !wr_n)) || (ad_oe && !rd_n)), 0);
            if (acc_flag) begin
                acc_flag = 0;
                acc_cyc  = ncyc - 1;
                accepted = 1;
                ale_cnt  = 0;
                stb_cnt  = 0;
                if (held_mode) begin
                    // next command is taken in the IDLE cycle that follows the 12 busy cycles
                    if (held_cnt > 0) chk("accept_gap", acc_cyc - prev_acc, A + S + P + H + R + 1);
                    held_cnt++;
                end
                prev_acc = acc_cyc;
            end
            if (!ale_n) begin
                ale_cnt++;
                if (exp_q.size() > 0) chk("ale_drive", {ad_oe, ad_out}, {1'b1, exp_q[0].addr});
            end
            if (ale_n && !ale_prev && exp_q.size() > 0 && !exp_q[0].write) in_read = 1;
            if (in_read) chk("read_oe", ad_oe, 0);
            if (!wr_n) begin
                stb_cnt++;
                if (exp_q.size() > 0) chk("wr_data", {ad_oe, ad_out}, {1'b1, exp_q[0].wdata});
            end
            if (!rd_n) stb_cnt++;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", rsp_err, e.err);
                    // cycle 0 is the first cycle after the accept edge
                    chk("rsp_latency", ncyc - acc_cyc - 1, e.lat);
                    chk("ale_len", ale_cnt, A);
                    chk("strobe_len", stb_cnt, e.stb_len);
                    exp_ready = e.lat + R;
                end
                in_read = 0;
            end
            if (cmd_ready && !ready_prev && accepted) chk("ready_return", ncyc - acc_cyc - 1, exp_ready);
            ready_prev = cmd_ready;
            ale_prev   = ale_n;
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input int stb, input logic terr);
        exp_t e;
        int   n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        e.write = w; e.addr = a; e.wdata = d; e.err = terr;
        e.stb_len = stb;
        e.lat = A + S + stb + H;
        if (terr)   e.rdata = 8'h00;
        else if (w) e.rdata = last_rdata;
        else        e.rdata = mdl_read(a);
        if (w && mdl_rw[a]) mdl_val[a] = d;
        last_rdata = e.rdata;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] addrs [0:5];
        logic [7:0] saved;
        int         n;
        for (int i = 0; i < 256; i++) begin
            mdl_val[i] = 8'h00;
            mdl_rw[i]  = 0;
        end
        mdl_rw[REG_TEST] = 1; mdl_rw[REG_FAULT] = 1; mdl_rw[REG_KICKER] = 1;

        // reset values
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {ale_n, rd_n, wr_n, ad_oe, cmd_ready, rsp_valid, rsp_err}, 7'b1110000);
        chk("reset_ad_out", ad_out, 8'h00);
        chk("reset_rdata", rsp_rdata, 8'h00);
        #2 rst_n = 1'b1;
        #1 chk("ready_after_release", cmd_ready, 0);
        @(negedge clk);
        chk("ready_idle", cmd_ready, 1);

        // write then read back the test register
        send(1'b1, REG_TEST, 8'h3C, P, 1'b0);
        idle(14);
        send(1'b0, REG_TEST, 8'h00, P, 1'b0);
        idle(14);

        // unmapped and status reads
        send(1'b0, 8'h55, 8'h00, P, 1'b0);
        idle(14);
        send(1'b0, REG_STATUS, 8'h00, P, 1'b0);
        idle(14);

        // three writes with cmd_valid held high
        held_mode = 1;
        send(1'b1, REG_FAULT, 8'h11, P, 1'b0);
        send(1'b1, REG_KICKER, 8'h22, P, 1'b0);
        send(1'b1, REG_TEST, 8'h33, P, 1'b0);
        idle(16);
        held_mode = 0;
        chk("held_accepts", held_cnt, 3);

        // reset during a write strobe must not disturb the responder
        send(1'b1, REG_FAULT, 8'hA5, P, 1'b0);
        idle(14);
        saved = mdl_val[REG_FAULT];
        send(1'b1, REG_FAULT, 8'h5A, P, 1'b0);
        cmd_valid = 1'b0;
        n = 0;
        while (wr_n && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wr_strobe_seen", wr_n, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_strobe", {wr_n, ad_oe, cmd_ready}, 3'b100);
        exp_q.delete();
        mdl_val[REG_FAULT] = saved;
        last_rdata = 8'h00;
        @(negedge clk);
        #3 rst_n = 1'b1;
        #1 chk("ready_after_mid_reset", cmd_ready, 0);
        send(1'b0, REG_FAULT, 8'h00, P, 1'b0);
        idle(14);

`ifdef MCU_BUS_WAIT_EN
        // responder never releases wait: the read times out
        wait_n = 1'b0;
        idle(4);
        send(1'b0, REG_TEST, 8'h00, P + T, 1'b1);
        idle(A + S + P + T + H + R + 6);
        wait_n = 1'b1;
        idle(4);
`endif

        // randomized traffic, sometimes back-to-back
        addrs[0] = REG_TEST; addrs[1] = REG_FAULT; addrs[2] = REG_KICKER;
        addrs[3] = REG_STATUS; addrs[4] = 8'h55; addrs[5] = 8'h00;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] a;
            a = addrs[$urandom_range(0, 5)];
            if ($urandom_range(0, 5) == 5) a = 8'($urandom);
            send(1'($urandom_range(0, 1)), a, 8'($urandom), P, 1'b0);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
        end
        idle(20);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
